i2c_byte_master: RTL

I2C_BYTE_MASTER -- requirements
Module: i2c_byte_master

---
 rtl/i2c_byte_master_pkg.sv | 35 +++
 rtl/i2c_quarter_timer.sv | 35 +++
 rtl/i2c_byte_master.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/i2c_byte_master_pkg.sv
// Shared I2C definitions: the command and bus-operation enums, the master FSM
// state type and the default data width used by the master and the i2c_if
// slave model.
package i2c_byte_master_pkg;

    // Matches the default data width of the i2c_if interface parameters.
    localparam int I2C_DATA_WIDTH_DEFAULT = 8;
    localparam int CLK_DIV_DEFAULT        = 4;

    // Slave-side transaction kind, as tracked by the i2c_if bus model.
    typedef enum logic [1:0] {
        OP_IDLE  = 2'd0,
        OP_ADDR  = 2'd1,
        OP_WRITE = 2'd2,
        OP_READ  = 2'd3
    } i2c_op_t;

    // Byte-level command accepted by i2c_byte_master.
    typedef enum logic [1:0] {
        CMD_START = 2'd0,
        CMD_STOP  = 2'd1,
        CMD_WRITE = 2'd2,
        CMD_READ  = 2'd3
    } i2c_cmd_t;

    // Master FSM state, exported on the debug port.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_BIT   = 3'd2,
        ST_STOP  = 3'd3,
        ST_RESP  = 3'd4
    } i2c_state_t;

endpackage

// File: rtl/i2c_quarter_timer.sv
// Quarter-period divider for the I2C master.
//   clk_i, rst_i : system clock, asynchronous active-high reset
//   load         : reload the divider (start of a new phase)
//   hold         : freeze the divider (slave is stretching SCL)
//   tick         : high on the last cycle of a quarter of exactly CLK_DIV
//                  non-held cycles; the divider reloads on the same edge
module i2c_quarter_timer #(
    parameter int CLK_DIV = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic load,
    input  logic hold,
    output logic tick
);

    localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = (cnt == '0) && !hold && !load;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt <= '0;
        end else if (load || tick) begin
            cnt <= RELOAD;
        end else if (!hold) begin
            // Only reached with cnt != 0: a zero count without hold ticks.
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/i2c_byte_master.sv
// Byte-level I2C master: executes START, STOP, WRITE and READ commands as
// sequences of quarter-period bus phases on open-drain SCL/SDA.
//   clk_i, rst_i          : clock, asynchronous active-high reset
//   cmd_valid/cmd_ready   : command handshake
//   cmd_op/data/nack      : command, write byte, master NACK for reads
//   rsp_valid             : one-cycle completion pulse
//   rsp_data/ack/err      : read byte (held), slave ACK for writes, rejection
//   bus_owned             : high between START and STOP completion
//   scl_i/sda_i           : sensed bus lines
//   scl_o/sda_o           : open-drain drive (0 pulls low, 1 releases)
//   dbg_state             : current FSM state
//
// Handshake: a command transfers on a rising edge where cmd_valid and
// cmd_ready are both 1. cmd_ready is 1 only in IDLE, and cmd_op, cmd_data and
// cmd_nack are captured on that edge, so later changes have no effect.
// rsp_valid is a single-cycle pulse with no back-pressure.
module i2c_byte_master
    import i2c_byte_master_pkg::*;
#(
    parameter int I2C_DATA_WIDTH = I2C_DATA_WIDTH_DEFAULT,
    parameter int CLK_DIV        = CLK_DIV_DEFAULT
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  i2c_cmd_t                  cmd_op,
    input  logic [I2C_DATA_WIDTH-1:0] cmd_data,
    input  logic                      cmd_nack,
    output logic                      rsp_valid,
    output logic [I2C_DATA_WIDTH-1:0] rsp_data,
    output logic                      rsp_ack,
    output logic                      rsp_err,
    output logic                      bus_owned,
    input  logic                      scl_i,
    input  logic                      sda_i,
    output logic                      scl_o,
    output logic                      sda_o,
    output i2c_state_t                dbg_state
);

    localparam int BW = $clog2(I2C_DATA_WIDTH + 1);
    // Bit index of the ACK bit (data bits are 0..I2C_DATA_WIDTH-1).
    localparam logic [BW-1:0] ACK_BIT  = BW'(I2C_DATA_WIDTH);
    localparam logic [BW-1:0] LAST_DAT = BW'(I2C_DATA_WIDTH - 1);

    i2c_state_t                state;
    logic [1:0]                quarter;
    logic [BW-1:0]             bit_cnt;
    i2c_cmd_t                  op_q;
    logic [I2C_DATA_WIDTH-1:0] shift_q;
    logic                      nack_q;
    logic                      ack_q;
    logic                      err_q;

    logic load;
    logic hold;
    logic tick;

    assign cmd_ready = (state == ST_IDLE);
    assign dbg_state = state;

    // Keep the divider primed while idle so the first quarter is full length.
    assign load = (state == ST_IDLE) || (state == ST_RESP);
    // SCL released but still low: the slave is stretching the clock.
    assign hold = (quarter == 2'd1) && scl_o && !scl_i;

    i2c_quarter_timer #(
        .CLK_DIV (CLK_DIV)
    ) u_timer (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .load  (load),
        .hold  (hold),
        .tick  (tick)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= ST_IDLE;
            quarter   <= 2'd0;
            bit_cnt   <= '0;
            op_q      <= CMD_START;
            shift_q   <= '0;
            nack_q    <= 1'b0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            scl_o     <= 1'b1;
            sda_o     <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_ack   <= 1'b0;
            rsp_data  <= '0;
            bus_owned <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // scl_o/sda_o keep their last values while idle.
                    if (cmd_valid) begin
                        op_q    <= cmd_op;
                        shift_q <= cmd_data;
                        nack_q  <= cmd_nack;
                        quarter <= 2'd0;
                        bit_cnt <= '0;
                        err_q   <= 1'b0;
                        case (cmd_op)
                            CMD_START: begin
                                state <= ST_START;
                                sda_o <= 1'b1;
                            end
                            CMD_STOP: begin
                                if (bus_owned) begin
                                    state <= ST_STOP;
                                    sda_o <= 1'b0;
                                end else begin
                                    state <= ST_RESP;
                                    err_q <= 1'b1;
                                end
                            end
                            default: begin
                                if (bus_owned) begin
                                    state <= ST_BIT;
                                    sda_o <= (cmd_op == CMD_WRITE) ?
                                             cmd_data[I2C_DATA_WIDTH-1] : 1'b1;
                                end else begin
                                    state <= ST_RESP;
                                    err_q <= 1'b1;
                                end
                            end
                        endcase
                    end
                end

                ST_START: begin
                    if (tick) begin
                        quarter <= quarter + 2'd1;
                        case (quarter)
                            2'd0:    scl_o <= 1'b1;
                            2'd1:    sda_o <= 1'b0;   // SDA falls with SCL high
                            2'd2:    scl_o <= 1'b0;
                            default: begin
                                bus_owned <= 1'b1;
                                state     <= ST_RESP;
                            end
                        endcase
                    end
                end

                ST_STOP: begin
                    if (tick) begin
                        quarter <= quarter + 2'd1;
                        case (quarter)
                            2'd0:    scl_o <= 1'b1;
                            2'd1:    sda_o <= 1'b1;   // SDA rises with SCL high
                            2'd2:    ;                // bus-free hold time
                            default: begin
                                bus_owned <= 1'b0;
                                state     <= ST_RESP;
                            end
                        endcase
                    end
                end

                ST_BIT: begin
                    if (tick) begin
                        quarter <= quarter + 2'd1;
                        case (quarter)
                            2'd0: scl_o <= 1'b1;
                            2'd1: ;
                            2'd2: begin
                                // Last cycle of the high phase: sample SDA.
                                scl_o <= 1'b0;
                                if (bit_cnt == ACK_BIT) begin
                                    ack_q <= ~sda_i;
                                end else begin
                                    // Writes shift their next bit into the MSB;
                                    // reads accumulate the received byte.
                                    shift_q <= {shift_q[I2C_DATA_WIDTH-2:0], sda_i};
                                end
                            end
                            default: begin
                                if (bit_cnt == ACK_BIT) begin
                                    state <= ST_RESP;
                                end else begin
                                    bit_cnt <= bit_cnt + 1'b1;
                                    if (bit_cnt == LAST_DAT) begin
                                        sda_o <= (op_q == CMD_WRITE) ? 1'b1 : nack_q;
                                    end else begin
                                        sda_o <= (op_q == CMD_WRITE) ?
                                                 shift_q[I2C_DATA_WIDTH-1] : 1'b1;
                                    end
                                end
                            end
                        endcase
                    end
                end

                ST_RESP: begin
                    rsp_valid <= 1'b1;
                    rsp_err   <= err_q;
                    rsp_ack   <= !err_q && (op_q == CMD_WRITE) && ack_q;
                    if (!err_q && (op_q == CMD_READ)) begin
                        rsp_data <= shift_q;
                    end
                    state <= ST_IDLE;
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
